// File: rtl/mini_mips_pkg.sv
// Shared definitions for the mini MIPS boot path: loader states and framing constants.
package mini_mips_pkg;

   typedef enum logic [2:0] {
      LdrLenHi,
      LdrLenLo,
      LdrData,
      LdrCsum,
      LdrDone,
      LdrErr
   } ldr_state_e;

   localparam int unsigned LDR_LEN_BYTES = 2;
   localparam int unsigned WORD_BYTES    = 4;

endpackage

// File: rtl/imem_loader_word_assembler.sv
// word_assembler: collects bytes MSB first into 32-bit words.
// word_valid flags the 4th byte of a word; word is valid in that same cycle.
module word_assembler
   import mini_mips_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        clear,
   input  logic        byte_valid,
   input  logic [7:0]  byte_data,
   output logic        word_valid,
   output logic [31:0] word
);

   logic [1:0]  phase_q;
   logic [23:0] shift_q;

   assign word_valid = byte_valid && (phase_q == 2'(WORD_BYTES - 1));
   assign word       = {shift_q, byte_data};

   always_ff @(posedge clk) begin
      if (!reset) begin
         phase_q <= 2'd0;
         shift_q <= 24'd0;
      end else if (clear) begin
         phase_q <= 2'd0;
         shift_q <= 24'd0;
      end else if (byte_valid) begin
         phase_q <= phase_q + 2'd1;
         shift_q <= {shift_q[15:0], byte_data};
      end
   end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: framed byte stream in, word writes to instruction memory out.
// Optional trailing XOR checksum byte enabled by `define IMEM_LOADER_CSUM_EN.
module imem_loader
   import mini_mips_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   parameter int unsigned DEPTH_WORDS = 256
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        rearm,
   input  logic        in_valid,
   input  logic [7:0]  in_data,
   output logic        in_ready,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [15:0] words_loaded,
   output logic        cpu_hold,
   output logic        done,
   output logic        error
);

`ifdef IMEM_LOADER_CSUM_EN
   localparam ldr_state_e StAfterData = LdrCsum;
   logic [7:0] csum_q;
`else
   localparam ldr_state_e StAfterData = LdrDone;
`endif

   ldr_state_e  state_q, state_d;
   logic        in_ready_q, mem_we_q, done_q, error_q, hold_q;
   logic [31:0] mem_addr_q, mem_wdata_q;
   logic [15:0] words_q, len_q, len_next;
   logic [7:0]  len_hi_q;
   logic        accept, clear, last_word, word_valid;
   logic [31:0] word;

   assign accept    = in_valid && in_ready_q;
   assign clear     = rearm && (state_q == LdrDone || state_q == LdrErr);
   assign len_next  = {len_hi_q, in_data};
   assign last_word = (words_q + 16'd1) == len_q;

   word_assembler u_word_assembler (
      .clk        (clk),
      .reset      (reset),
      .clear      (clear),
      .byte_valid (accept && (state_q == LdrData)),
      .byte_data  (in_data),
      .word_valid (word_valid),
      .word       (word)
   );

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         LdrLenHi: if (accept) state_d = LdrLenLo;
         LdrLenLo: begin
            if (accept) begin
               if (32'(len_next) > DEPTH_WORDS) state_d = LdrErr;
               else if (len_next == 16'd0)      state_d = StAfterData;
               else                             state_d = LdrData;
            end
         end
         LdrData: if (word_valid && last_word) state_d = StAfterData;
         LdrCsum: begin
`ifdef IMEM_LOADER_CSUM_EN
            if (accept) state_d = (in_data == csum_q) ? LdrDone : LdrErr;
`else
            state_d = LdrErr;
`endif
         end
         LdrDone, LdrErr: if (rearm) state_d = LdrLenHi;
         default: state_d = LdrLenHi;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= LdrLenHi;
         in_ready_q  <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= BASE_ADDR;
         mem_wdata_q <= 32'd0;
         words_q     <= 16'd0;
         len_q       <= 16'd0;
         len_hi_q    <= 8'd0;
         done_q      <= 1'b0;
         error_q     <= 1'b0;
         hold_q      <= 1'b1;
      end else begin
         state_q    <= state_d;
         // Status flags follow the state being entered so they line up with it.
         in_ready_q <= (state_d == LdrLenHi) || (state_d == LdrLenLo) ||
                       (state_d == LdrData)  || (state_d == LdrCsum);
         done_q     <= (state_d == LdrDone);
         error_q    <= (state_d == LdrErr);
         hold_q     <= (state_d != LdrDone);
         mem_we_q   <= word_valid;
         if (word_valid) begin
            mem_addr_q  <= BASE_ADDR + {14'd0, words_q, 2'b00};
            mem_wdata_q <= word;
            words_q     <= words_q + 16'd1;
         end
         if (clear) words_q <= 16'd0;
         if (accept && state_q == LdrLenHi) len_hi_q <= in_data;
         if (accept && state_q == LdrLenLo) len_q <= len_next;
      end
   end

`ifdef IMEM_LOADER_CSUM_EN
   always_ff @(posedge clk) begin
      if (!reset || clear) csum_q <= 8'd0;
      else if (accept && state_q != LdrCsum) csum_q <= csum_q ^ in_data;
   end
`endif

   assign in_ready     = in_ready_q;
   assign mem_we       = mem_we_q;
   assign mem_addr     = mem_addr_q;
   assign mem_wdata    = mem_wdata_q;
   assign words_loaded = words_q;
   assign cpu_hold     = hold_q;
   assign done         = done_q;
   assign error        = error_q;

endmodule
